// File: rtl/fwrisc_regfile_p.sv
// Parametrised integer register file for fwrisc: hardware zero-fill after reset,
// N registered read ports with optional write-to-read forwarding, 64-bit cycle/instret counters.
module fwrisc_regfile_p #(
    parameter int XLEN            = 32,
    parameter int NREGS           = 32,
    parameter int NRPORTS         = 2,
    parameter int BYPASS          = 1,
    parameter int ENABLE_COUNTERS = 1
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_instr_complete,
    input  logic [NRPORTS*$clog2(NREGS)-1:0]    i_raddr,
    output logic [NRPORTS*XLEN-1:0]             o_rdata,
    input  logic [$clog2(NREGS)-1:0]            i_waddr,
    input  logic [XLEN-1:0]                     i_wdata,
    input  logic                                i_wen,
    output logic                                o_init_busy,
    output logic [63:0]                         o_cycle_count,
    output logic [63:0]                         o_instr_count,
    output logic                                o_dbg_state
);

    localparam int              AW       = $clog2(NREGS);
    localparam logic [AW-1:0]   LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_clr_idx;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic              w_run;
    logic              w_wr;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR)
                r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_init_busy  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_init_busy = 1'b1;
                if (r_clr_idx == LAST_IDX)
                    w_state_next = ST_RUN;
            end
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_wr        = w_run && i_wen && (i_waddr != '0);
    assign o_dbg_state = r_state;

    // Storage is deliberately not reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge i_clock) begin
        if (!w_run)
            r_regs[r_clr_idx] <= '0;
        else if (w_wr)
            r_regs[i_waddr] <= i_wdata;
    end

    for (genvar p = 0; p < NRPORTS; p++) begin : g_rport
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] r_rd;

        assign w_ra = i_raddr[p*AW +: AW];

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset)
                r_rd <= '0;
            else if (!w_run || w_ra == '0)
                r_rd <= '0;
            else if (BYPASS != 0 && i_wen && i_waddr == w_ra)
                r_rd <= i_wdata;
            else
                r_rd <= r_regs[w_ra];
        end

        assign o_rdata[p*XLEN +: XLEN] = r_rd;
    end

    if (ENABLE_COUNTERS != 0) begin : g_counters
        logic [63:0] r_cycle_count;
        logic [63:0] r_instr_count;

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                r_cycle_count <= '0;
                r_instr_count <= '0;
            end else begin
                r_cycle_count <= r_cycle_count + 64'd1;
                if (w_run && i_instr_complete)
                    r_instr_count <= r_instr_count + 64'd1;
            end
        end

        assign o_cycle_count = r_cycle_count;
        assign o_instr_count = r_instr_count;
    end else begin : g_no_counters
        assign o_cycle_count = '0;
        assign o_instr_count = '0;
    end

endmodule
